// File: rtl/agc_pkg.sv
// agc_pkg: shared definitions for the closed-loop AGC.
//   mode_t          : operating-mode encodings presented on i_mode
//   GAIN_ONE        : unity gain in the default gain format (F_GAIN = 12)
//   sat_signed      : clip a wide signed value into a signed field of 'width' bits
//   clamp_unsigned  : clamp a wide signed value into [lo, hi]
package agc_pkg;

    typedef enum logic [1:0] {
        MODE_TRACK    = 2'b00,
        MODE_HOLD     = 2'b01,
        MODE_FIXED    = 2'b10,
        MODE_HOLD_ALT = 2'b11
    } mode_t;

    localparam int GAIN_ONE = 4096;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int                  width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic signed [63:0] clamp_unsigned(input logic signed [63:0] x,
                                                          input logic signed [63:0] lo,
                                                          input logic signed [63:0] hi);
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/agc_ema.sv
// agc_ema: first-order exponential moving average of the output magnitude.
//   clk, reset : clock, synchronous active-high reset (envelope cleared)
//   mag        : unsigned magnitude sample, W bits
//   mag_vld    : magnitude qualifier; the envelope only moves when set
//   coef       : EMA coefficient, unsigned with F_A fraction bits
//   env        : envelope state
//   env_vld    : one-cycle strobe marking a freshly updated envelope
module agc_ema
    import agc_pkg::*;
#(
    parameter int W   = 17,
    parameter int W_A = 16,
    parameter int F_A = 14
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   mag,
    input  logic           mag_vld,
    input  logic [W_A-1:0] coef,
    output logic [W-1:0]   env,
    output logic           env_vld
);

    localparam logic signed [63:0] ENV_MAX = (64'sd1 <<< W) - 64'sd1;

    logic signed [63:0] env_s;
    logic signed [63:0] diff;
    logic signed [63:0] upd;

    // env + ((mag - env) * a) >>> F_A; the arithmetic shift floors toward -inf
    always_comb begin
        env_s = $signed({{(64-W){1'b0}}, env});
        diff  = $signed({{(64-W){1'b0}}, mag}) - env_s;
        upd   = (diff * $signed({{(64-W_A){1'b0}}, coef})) >>> F_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            env     <= '0;
            env_vld <= 1'b0;
        end else begin
            env_vld <= mag_vld;
            if (mag_vld)
                env <= W'(clamp_unsigned(env_s + upd, 64'sd0, ENV_MAX));
        end
    end

endmodule

// File: rtl/agc_loop.sv
// agc_loop: closed-loop AGC for one complex I/Q channel.
//   clk, reset           : clock, synchronous active-high reset
//   i_mode               : 00 track, 01 hold, 10 fixed, 11 hold
//   i_alpha              : loop speed, F_ALPHA fraction bits
//   i_a                  : EMA coefficient, F_A fraction bits
//   i_reference          : target envelope (units of |I|+|Q|)
//   i_fixed_gain         : gain loaded every cycle in fixed mode
//   i_lock_thr           : lock window on |reference - envelope|
//   s_chans_data{I,Q}    : input sample, s_chans_valid qualifier
//   m_chans_data{I,Q}    : gained/saturated sample, m_chans_valid qualifier (2-cycle latency)
//   o_gain, o_envelope   : gain register and EMA state
//   o_locked             : LOCK_CNT consecutive in-window track updates seen
//   o_sat                : last output sample clipped in I or Q
module agc_loop
    import agc_pkg::*;
#(
    parameter int W_IN      = 16,
    parameter int W_OUT     = 16,
    parameter int W_GAIN    = 16,
    parameter int F_GAIN    = 12,
    parameter int W_ALPHA   = 16,
    parameter int F_ALPHA   = 14,
    parameter int W_A       = 16,
    parameter int F_A       = 14,
    parameter int GAIN_INIT = GAIN_ONE,
    parameter int GAIN_MIN  = 16,
    parameter int GAIN_MAX  = 65535,
    parameter int LOCK_CNT  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               i_mode,
    input  logic [W_ALPHA-1:0]       i_alpha,
    input  logic [W_A-1:0]           i_a,
    input  logic [W_OUT:0]           i_reference,
    input  logic [W_GAIN-1:0]        i_fixed_gain,
    input  logic [W_OUT:0]           i_lock_thr,
    input  logic signed [W_IN-1:0]   s_chans_dataI,
    input  logic signed [W_IN-1:0]   s_chans_dataQ,
    input  logic                     s_chans_valid,
    output logic signed [W_OUT-1:0]  m_chans_dataI,
    output logic signed [W_OUT-1:0]  m_chans_dataQ,
    output logic                     m_chans_valid,
    output logic [W_GAIN-1:0]        o_gain,
    output logic [W_OUT:0]           o_envelope,
    output logic                     o_locked,
    output logic                     o_sat
);

    localparam int MW = W_OUT + 1;
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]      CNT_MAX = CW'(LOCK_CNT);
    localparam logic signed [63:0] RND     = 64'sd1 <<< (F_GAIN - 1);

    mode_t mode;
    assign mode = mode_t'(i_mode);

    logic signed [W_IN-1:0] i_p0;
    logic signed [W_IN-1:0] q_p0;
    logic                   vld_p0;
    logic [W_GAIN-1:0]      gain;
    logic [MW-1:0]          env;
    logic                   vld_p2;
    logic [MW-1:0]          mag;
    logic [CW-1:0]          lock_cnt;

    // Stage A: capture the input sample
    always_ff @(posedge clk) begin
        if (reset)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= s_chans_valid;
    end

    always_ff @(posedge clk) begin
        if (s_chans_valid) begin
            i_p0 <= s_chans_dataI;
            q_p0 <= s_chans_dataQ;
        end
    end

    // Stage B: round-half-up gain multiply, then clip to the output width
    logic signed [63:0] gain_s;
    logic signed [63:0] rnd_i, rnd_q;
    logic signed [63:0] sat_i, sat_q;

    always_comb begin
        gain_s = $signed({{(64-W_GAIN){1'b0}}, gain});
        rnd_i  = ($signed({{(64-W_IN){i_p0[W_IN-1]}}, i_p0}) * gain_s + RND) >>> F_GAIN;
        rnd_q  = ($signed({{(64-W_IN){q_p0[W_IN-1]}}, q_p0}) * gain_s + RND) >>> F_GAIN;
        sat_i  = sat_signed(rnd_i, W_OUT);
        sat_q  = sat_signed(rnd_q, W_OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_chans_valid <= 1'b0;
            m_chans_dataI <= '0;
            m_chans_dataQ <= '0;
            o_sat         <= 1'b0;
        end else begin
            m_chans_valid <= vld_p0;
            if (vld_p0) begin
                m_chans_dataI <= sat_i[W_OUT-1:0];
                m_chans_dataQ <= sat_q[W_OUT-1:0];
                o_sat         <= (sat_i != rnd_i) || (sat_q != rnd_q);
            end
        end
    end

    // Detector: |I|+|Q| of the registered output; needs one extra bit so that
    // two full-scale negative components (2^(W_OUT-1) each) do not wrap
    logic signed [63:0] abs_i, abs_q;

    always_comb begin
        abs_i = $signed({{(64-W_OUT){m_chans_dataI[W_OUT-1]}}, m_chans_dataI});
        abs_q = $signed({{(64-W_OUT){m_chans_dataQ[W_OUT-1]}}, m_chans_dataQ});
        if (abs_i < 0)
            abs_i = -abs_i;
        if (abs_q < 0)
            abs_q = -abs_q;
        mag = MW'(abs_i + abs_q);
    end

    agc_ema #(
        .W   (MW),
        .W_A (W_A),
        .F_A (F_A)
    ) u_ema (
        .clk     (clk),
        .reset   (reset),
        .mag     (mag),
        .mag_vld (m_chans_valid),
        .coef    (i_a),
        .env     (env),
        .env_vld (vld_p2)
    );

    // Gain update: driven by the fresh envelope; stage B on the same edge
    // still sees the old gain because both read the register before the edge
    logic signed [63:0] err;
    logic signed [63:0] err_abs;
    logic signed [63:0] step;

    always_comb begin
        err     = $signed({{(64-MW){1'b0}}, i_reference}) - $signed({{(64-MW){1'b0}}, env});
        err_abs = (err < 0) ? -err : err;
        step    = (err * $signed({{(64-W_ALPHA){1'b0}}, i_alpha})) >>> F_ALPHA;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gain <= W_GAIN'(GAIN_INIT);
        end else begin
            case (mode)
                MODE_FIXED: gain <= i_fixed_gain;
                MODE_TRACK: begin
                    if (vld_p2)
                        gain <= W_GAIN'(clamp_unsigned(gain_s + step,
                                                       64'(GAIN_MIN), 64'(GAIN_MAX)));
                end
                default:    gain <= gain;
            endcase
        end
    end

    // Lock counter only runs on track-mode updates; any other mode clears it
    always_ff @(posedge clk) begin
        if (reset || mode != MODE_TRACK) begin
            lock_cnt <= '0;
        end else if (vld_p2) begin
            if (err_abs <= $signed({{(64-MW){1'b0}}, i_lock_thr}))
                lock_cnt <= (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
            else
                lock_cnt <= '0;
        end
    end

    assign o_locked   = (lock_cnt == CNT_MAX);
    assign o_gain     = gain;
    assign o_envelope = env;

endmodule

// File: tb/tb_agc_loop.sv
// tb_agc_loop: self-checking bench for agc_loop. A per-edge reference model
// predicts each output sample when it is accepted and queues it; the queue is
// drained as the model's output valid fires and every cycle the DUT outputs,
// gain, envelope and lock flag are compared with the model. A table of fixed-
// gain vectors and hand-written mode/clamp/reset sequences add literal checks.
module tb_agc_loop;

    localparam longint LOCK_CNT = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         i_mode;
    logic [15:0]        i_alpha;
    logic [15:0]        i_a;
    logic [16:0]        i_reference;
    logic [15:0]        i_fixed_gain;
    logic [16:0]        i_lock_thr;
    logic signed [15:0] s_I, s_Q;
    logic               s_valid;
    logic signed [15:0] m_I, m_Q;
    logic               m_valid;
    logic [15:0]        o_gain;
    logic [16:0]        o_envelope;
    logic               o_locked;
    logic               o_sat;

    always #5 clk = ~clk;

    agc_loop dut (
        .clk           (clk),
        .reset         (reset),
        .i_mode        (i_mode),
        .i_alpha       (i_alpha),
        .i_a           (i_a),
        .i_reference   (i_reference),
        .i_fixed_gain  (i_fixed_gain),
        .i_lock_thr    (i_lock_thr),
        .s_chans_dataI (s_I),
        .s_chans_dataQ (s_Q),
        .s_chans_valid (s_valid),
        .m_chans_dataI (m_I),
        .m_chans_dataQ (m_Q),
        .m_chans_valid (m_valid),
        .o_gain        (o_gain),
        .o_envelope    (o_envelope),
        .o_locked      (o_locked),
        .o_sat         (o_sat)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        longint oi;
        longint oq;
        bit     sat;
    } exp_t;

    exp_t   sb[$];
    longint md_g, md_env, md_mI, md_mQ;
    bit     md_sat, md_v0, md_v1, md_v2;
    longint md_cnt;

    typedef struct {
        logic [15:0]        gain;
        logic signed [15:0] xi;
        logic signed [15:0] xq;
        longint             ei;
        longint             eq;
        bit                 es;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint absl(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // Expected output for sample (x, y) multiplied by gain g
    function automatic exp_t predict(input longint x, input longint y, input longint g);
        exp_t   e;
        longint ri, rq;
        ri    = (x * g + 2048) >>> 12;
        rq    = (y * g + 2048) >>> 12;
        e.oi  = clampl(ri, -32768, 32767);
        e.oq  = clampl(rq, -32768, 32767);
        e.sat = (e.oi != ri) || (e.oq != rq);
        return e;
    endfunction

    // Reference model advance for one rising edge, using the inputs held now
    task automatic model_step();
        longint err, nxt_g, nxt_env, mag;
        exp_t   e;
        if (reset) begin
            md_g = 4096; md_env = 0; md_cnt = 0;
            md_mI = 0; md_mQ = 0; md_sat = 1'b0;
            md_v0 = 1'b0; md_v1 = 1'b0; md_v2 = 1'b0;
            sb.delete();
        end else begin
            mag     = absl(md_mI) + absl(md_mQ);
            nxt_env = md_env;
            if (md_v1)
                nxt_env = clampl(md_env + (((mag - md_env) * longint'(i_a)) >>> 14), 0, 131071);
            err   = longint'(i_reference) - md_env;
            nxt_g = md_g;
            if (i_mode == 2'b10)
                nxt_g = longint'(i_fixed_gain);
            else if (i_mode == 2'b00 && md_v2)
                nxt_g = clampl(md_g + ((err * longint'(i_alpha)) >>> 14), 16, 65535);
            if (i_mode != 2'b00)
                md_cnt = 0;
            else if (md_v2)
                md_cnt = (absl(err) <= longint'(i_lock_thr)) ?
                         ((md_cnt < LOCK_CNT) ? md_cnt + 1 : LOCK_CNT) : 0;
            if (md_v0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow actual=0 required=1");
                end else begin
                    e = sb.pop_front();
                    md_mI = e.oi; md_mQ = e.oq; md_sat = e.sat;
                end
            end
            md_v2 = md_v1;
            md_v1 = md_v0;
            md_v0 = s_valid;
            if (s_valid)
                sb.push_back(predict(longint'(s_I), longint'(s_Q), nxt_g));
            md_env = nxt_env;
            md_g   = nxt_g;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (chk_en) begin
            check("m_valid", 64'(m_valid), 64'(md_v1));
            check("m_dataI", 64'(m_I), md_mI);
            check("m_dataQ", 64'(m_Q), md_mQ);
            check("o_sat", 64'(o_sat), 64'(md_sat));
            check("o_gain", 64'(o_gain), md_g);
            check("o_envelope", 64'(o_envelope), md_env);
            check("o_locked", 64'(o_locked), 64'(md_cnt == LOCK_CNT));
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        int     pulses;
        longint g_hold;

        tbl[0] = '{16'd4096,  16'sd1000,   -16'sd500,   1000,   -500,   1'b0};
        tbl[1] = '{16'd16384, 16'sd10000,  -16'sd32768, 32767,  -32768, 1'b1};
        tbl[2] = '{16'd16384, 16'sd100,    16'sd0,      400,    0,      1'b0};
        tbl[3] = '{16'd2048,  16'sd3,      -16'sd3,     2,      -1,     1'b0};
        tbl[4] = '{16'd65535, 16'sd32767,  -16'sd32768, 32767,  -32768, 1'b1};
        tbl[5] = '{16'd4096,  -16'sd32768, 16'sd32767,  -32768, 32767,  1'b0};
        tbl[6] = '{16'd4097,  -16'sd32768, 16'sd0,      -32768, 0,      1'b1};

        reset = 1'b1; s_valid = 1'b0; i_mode = 2'b00;
        i_alpha = 16'd1024; i_a = 16'd4096; i_reference = 17'd4000;
        i_fixed_gain = 16'd4096; i_lock_thr = 17'd32;
        s_I = '0; s_Q = '0;
        tick();
        chk_en = 1'b1;
        do_reset();
        check("rst_gain", 64'(o_gain), 4096);
        check("rst_env", 64'(o_envelope), 0);
        check("rst_locked", 64'(o_locked), 0);
        check("rst_valid", 64'(m_valid), 0);
        check("rst_sat", 64'(o_sat), 0);

        // Fixed-gain vector table: one isolated sample each
        i_mode = 2'b10;
        for (int v = 0; v < 7; v++) begin
            i_fixed_gain = tbl[v].gain;
            s_I = tbl[v].xi; s_Q = tbl[v].xq; s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            pulses  = 0;
            tick();
            pulses += int'(m_valid);
            check("vec_valid", 64'(m_valid), 1);
            check("vec_I", 64'(m_I), tbl[v].ei);
            check("vec_Q", 64'(m_Q), tbl[v].eq);
            check("vec_sat", 64'(o_sat), 64'(tbl[v].es));
            repeat (2) begin
                tick();
                pulses += int'(m_valid);
            end
            check("vec_pulses", 64'(pulses), 1);
        end

        // Mode 11 holds the gain even while i_fixed_gain moves
        i_fixed_gain = 16'd8192;
        repeat (2) tick();
        i_mode = 2'b11; i_fixed_gain = 16'd1234;
        s_I = 16'sd2000; s_Q = 16'sd2000; s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("hold11_gain", 64'(o_gain), 8192);
            if (k >= 1) begin
                check("hold11_I", 64'(m_I), 4000);
                check("hold11_Q", 64'(m_Q), 4000);
            end
        end

        // Track convergence and lock. The floored loop step leaves a dead zone
        // of up to 16 below the reference, so the lock window is wider than it.
        do_reset();
        i_mode = 2'b00; i_alpha = 16'd1024; i_a = 16'd4096;
        i_reference = 17'd4000; i_lock_thr = 17'd32;
        s_I = 16'sd1000; s_Q = 16'sd1000; s_valid = 1'b1;
        repeat (3000) tick();
        check("trk_gain_near", 64'(o_gain >= 16'd8128 && o_gain <= 16'd8256), 1);
        check("trk_env_near", 64'(o_envelope >= 17'd3976 && o_envelope <= 17'd4024), 1);
        check("trk_locked", 64'(o_locked), 1);

        // Hold after lock: lock drops on the next cycle, gain frozen
        g_hold = md_g;
        i_mode = 2'b01; s_I = 16'sd2000; s_Q = 16'sd2000;
        tick();
        check("hold_unlock", 64'(o_locked), 0);
        repeat (20) tick();
        check("hold_gain", 64'(o_gain), g_hold);

        // Fixed then track: tracking resumes from the fixed gain
        i_mode = 2'b10; i_fixed_gain = 16'd6000; s_I = 16'sd1000; s_Q = 16'sd1000;
        repeat (5) tick();
        i_mode = 2'b00;
        repeat (200) tick();

        // Reset with samples in both stages: nothing emerges afterwards
        reset = 1'b1;
        tick();
        reset = 1'b0; s_valid = 1'b0;
        check("mrst_gain", 64'(o_gain), 4096);
        check("mrst_env", 64'(o_envelope), 0);
        check("mrst_locked", 64'(o_locked), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mrst_no_valid", 64'(m_valid), 0);
        end

        // Upper gain clamp
        do_reset();
        i_mode = 2'b00; i_reference = 17'd65535;
        s_I = 16'sd1; s_Q = 16'sd1; s_valid = 1'b1;
        repeat (200) tick();
        check("clamp_hi", 64'(o_gain), 65535);

        // Lower gain clamp
        do_reset();
        i_reference = 17'd0; s_I = 16'sd30000; s_Q = 16'sd30000; s_valid = 1'b1;
        repeat (200) tick();
        check("clamp_lo", 64'(o_gain), 16);

        s_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
